// File: rtl/myuart_fifo.sv
// Single-clock Avalon-MM UART with RX/TX byte FIFOs, sticky error flags and a level IRQ.
// Registers 0 and 1 keep the bit layout of the older single-byte UART.
module myuart_fifo #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  output logic [31:0] avs_s0_readdata,
  input  logic [31:0] avs_s0_writedata,
  output logic        avs_s0_waitrequest,
  input  logic [3:0]  avs_s0_byteenable,
  output logic        ins_irq0_irq,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] BIT_END  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic rd_rx, wr_tx, wr_stat, wr_ctrl;
  assign rd_rx   = avs_s0_read  && (avs_s0_address == 2'd0);
  assign wr_tx   = avs_s0_write && (avs_s0_address == 2'd1);
  assign wr_stat = avs_s0_write && (avs_s0_address == 2'd2);
  assign wr_ctrl = avs_s0_write && (avs_s0_address == 2'd3);
  assign avs_s0_waitrequest = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{avs_s0_byteenable, avs_s0_writedata[31:8]};

  // FIFO storage and pointers
  logic [7:0]         rx_mem [DEPTH];
  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0]      rx_cnt, tx_cnt;
  logic rx_valid, rx_full, tx_full, tx_idle;
  logic rx_push_req, rx_push, rx_pop, rx_ovf_set;
  logic tx_push, tx_pop, tx_ovf_set;
  logic frame_err_set;
  logic rx_ovf, frame_err, tx_ovf, rxie, txie;

  assign rx_valid   = (rx_cnt != CW'(0));
  assign rx_full    = (rx_cnt == CNT_FULL);
  assign tx_full    = (tx_cnt == CNT_FULL);
  assign rx_pop     = rd_rx && rx_valid;
  assign rx_push    = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_push_req && rx_full && !rx_pop;
  assign tx_push    = wr_tx && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_tx && tx_full && !tx_pop;

  // TX FSM
  state_t      tx_state, tx_state_d;
  logic [DW-1:0] tx_tick, tx_tick_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_shift, tx_shift_d;
  logic        txd_q, txd_d;

  assign tx_idle  = (tx_cnt == CW'(0)) && (tx_state == S_IDLE);
  assign uart_txd = txd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_tick  <= tx_tick_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      txd_q    <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_tick_d  = tx_tick + DW'(1);
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    unique case (tx_state)
      S_IDLE: begin
        tx_tick_d = '0;
        if (tx_cnt != CW'(0)) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rp];
          txd_d      = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_tick == BIT_END) begin
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift[0];
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_tick == BIT_END) begin
          tx_tick_d = '0;
          if (tx_bit == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift[7:1]};
            txd_d      = tx_shift[1];
            tx_bit_d   = tx_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tx_tick == BIT_END) begin
          tx_tick_d = '0;
          // Chain straight into the next frame so there is no idle gap
          if (tx_cnt != CW'(0)) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rp];
            txd_d      = 1'b0;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // RX synchroniser plus one stage of history for falling-edge detection
  logic rxd_meta, rxd_sync, rxd_prev;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // RX FSM
  state_t        rx_state, rx_state_d;
  logic [DW-1:0] rx_tick, rx_tick_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_shift, rx_shift_d;
  logic          rx_wait, rx_wait_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= S_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_wait  <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_tick  <= rx_tick_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
      rx_wait  <= rx_wait_d;
    end
  end

  always_comb begin
    rx_state_d    = rx_state;
    rx_tick_d     = rx_tick + DW'(1);
    rx_bit_d      = rx_bit;
    rx_shift_d    = rx_shift;
    rx_wait_d     = rx_wait;
    rx_push_req   = 1'b0;
    frame_err_set = 1'b0;
    unique case (rx_state)
      S_IDLE: begin
        rx_tick_d = '0;
        if (rxd_prev && !rxd_sync) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_tick == HALF_END) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tick == BIT_END) begin
          rx_tick_d  = '0;
          rx_shift_d = {rxd_sync, rx_shift[7:1]};
          rx_bit_d   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_wait) begin
          // Bad stop bit: hold off until the line returns high
          rx_tick_d = '0;
          if (rxd_sync) begin
            rx_wait_d  = 1'b0;
            rx_state_d = S_IDLE;
          end
        end else if (rx_tick == BIT_END) begin
          rx_tick_d = '0;
          if (rxd_sync) begin
            rx_push_req = 1'b1;
            rx_state_d  = S_IDLE;
          end else begin
            frame_err_set = 1'b1;
            rx_wait_d     = 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // FIFO pointer/count bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + FIFO_AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + FIFO_AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      if (tx_push) tx_wp <= tx_wp + FIFO_AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + FIFO_AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
    if (tx_push) tx_mem[tx_wp] <= avs_s0_writedata[7:0];
  end

  // Sticky flags (set beats clear), control and IRQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ovf       <= 1'b0;
      frame_err    <= 1'b0;
      tx_ovf       <= 1'b0;
      rxie         <= 1'b0;
      txie         <= 1'b0;
      ins_irq0_irq <= 1'b0;
    end else begin
      rx_ovf    <= rx_ovf_set    | (rx_ovf    & ~(wr_stat & avs_s0_writedata[3]));
      frame_err <= frame_err_set | (frame_err & ~(wr_stat & avs_s0_writedata[4]));
      tx_ovf    <= tx_ovf_set    | (tx_ovf    & ~(wr_stat & avs_s0_writedata[5]));
      if (wr_ctrl) begin
        rxie <= avs_s0_writedata[0];
        txie <= avs_s0_writedata[1];
      end
      ins_irq0_irq <= (rxie & rx_valid) | (txie & tx_idle);
    end
  end

  always_comb begin
    avs_s0_readdata = '0;
    unique case (avs_s0_address)
      2'd0: avs_s0_readdata = {22'b0, rx_ovf, rx_valid, (rx_valid ? rx_mem[rx_rp] : 8'h00)};
      2'd1: avs_s0_readdata = {23'b0, tx_full, 8'b0};
      2'd2: avs_s0_readdata = {8'b0, 8'(tx_cnt), 8'(rx_cnt), 2'b0,
                               tx_ovf, frame_err, rx_ovf, tx_idle, tx_full, rx_valid};
      2'd3: avs_s0_readdata = {30'b0, txie, rxie};
      default: avs_s0_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_myuart_fifo.sv
// Directed bench for myuart_fifo (CLK_DIV=8, FIFO_AW=2): register table plus
// loopback, overflow, framing, IRQ and mid-frame reset sequences.
module tb_myuart_fifo;

  localparam int unsigned DIV = 8;

  logic        clk;
  logic        reset_n;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_readdata;
  logic [31:0] avs_s0_writedata;
  logic        avs_s0_waitrequest;
  logic [3:0]  avs_s0_byteenable;
  logic        ins_irq0_irq;
  logic        uart_rxd;
  logic        uart_txd;
  logic        drv_rxd;
  logic        loop_en;

  int checks = 0;
  int errors = 0;

  assign uart_rxd = loop_en ? uart_txd : drv_rxd;

  myuart_fifo #(.CLK_DIV(DIV), .FIFO_AW(2)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .avs_s0_address     (avs_s0_address),
    .avs_s0_read        (avs_s0_read),
    .avs_s0_write       (avs_s0_write),
    .avs_s0_readdata    (avs_s0_readdata),
    .avs_s0_writedata   (avs_s0_writedata),
    .avs_s0_waitrequest (avs_s0_waitrequest),
    .avs_s0_byteenable  (avs_s0_byteenable),
    .ins_irq0_irq       (ins_irq0_irq),
    .uart_rxd           (uart_rxd),
    .uart_txd           (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus tasks are entered right after a negedge and return at the next one
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_write     = 1'b1;
    @(negedge clk);
    avs_s0_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    #1;
    d = avs_s0_readdata;
    @(negedge clk);
    avs_s0_read    = 1'b0;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drv_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    drv_rxd = stop_bit;
    repeat (DIV) @(negedge clk);
  endtask

  // Decode one frame off uart_txd, sampling mid-bit; found=0 on timeout
  task automatic grab_tx(output logic [7:0] b, output logic found);
    int t = 0;
    b = '0;
    found = 1'b0;
    while (uart_txd !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t < 300) begin
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (DIV) @(negedge clk);
      found = (uart_txd === 1'b1);
    end
  endtask

  vec_t vecs[14];

  initial begin
    logic [7:0]  lb_bytes [2];
    logic [7:0]  gb;
    logic        gf;
    logic        expb;
    int          fi, bi;

    reset_n = 1'b0;
    avs_s0_address = '0;
    avs_s0_read = 1'b0;
    avs_s0_write = 1'b0;
    avs_s0_writedata = '0;
    avs_s0_byteenable = 4'hF;
    drv_rxd = 1'b1;
    loop_en = 1'b0;

    vecs[0]  = '{1'b0, 2'd2, 32'h0,        32'h0000_0004, "status_rst"};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0000, "rxdata_rst"};
    vecs[2]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0000, "txdata_rst"};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000, "control_rst"};
    vecs[4]  = '{1'b1, 2'd3, 32'h0000_0002, 32'h0,        "wr_ctrl_tx"};
    vecs[5]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0002, "control_txie"};
    vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFD, 32'h0,        "wr_ctrl_rx"};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0001, "control_rxie"};
    vecs[8]  = '{1'b1, 2'd3, 32'h0,        32'h0,        "wr_ctrl_0"};
    vecs[9]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000, "control_clr"};
    vecs[10] = '{1'b1, 2'd2, 32'h0000_0038, 32'h0,        "wr_stat_idle"};
    vecs[11] = '{1'b1, 2'd0, 32'h0000_00AB, 32'h0,        "wr_rxdata"};
    vecs[12] = '{1'b0, 2'd2, 32'h0,        32'h0000_0004, "status_after_wr"};
    vecs[13] = '{1'b0, 2'd0, 32'h0,        32'h0000_0000, "rxdata_still_empty"};

    repeat (3) @(negedge clk);
    check("rst_txd", {31'b0, uart_txd}, 32'h1);
    check("rst_irq", {31'b0, ins_irq0_irq}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("waitrequest", {31'b0, avs_s0_waitrequest}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else            read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    repeat (3) @(negedge clk);

    // Loopback: two back-to-back 80-cycle frames, checked cycle by cycle
    loop_en = 1'b1;
    lb_bytes[0] = 8'h55;
    lb_bytes[1] = 8'hA3;
    avs_s0_address = 2'd1;
    avs_s0_writedata = 32'h55;
    avs_s0_write = 1'b1;
    @(negedge clk);
    check("lb_txd_before_start", {31'b0, uart_txd}, 32'h1);
    avs_s0_writedata = 32'hA3;
    @(negedge clk);
    avs_s0_write = 1'b0;
    avs_s0_address = 2'd2;
    for (int k = 0; k < 160; k++) begin
      fi = k / 80;
      bi = (k % 80) / DIV;
      if (bi == 0)      expb = 1'b0;
      else if (bi == 9) expb = 1'b1;
      else              expb = lb_bytes[fi][bi-1];
      #1;
      check($sformatf("lb_txd_c%0d", k), {31'b0, uart_txd}, {31'b0, expb});
      if (k == 159) check("lb_busy_last_cycle", {31'b0, avs_s0_readdata[2]}, 32'h0);
      @(negedge clk);
    end
    #1;
    check("lb_txd_after", {31'b0, uart_txd}, 32'h1);
    check("lb_idle_exact", {31'b0, avs_s0_readdata[2]}, 32'h1);
    @(negedge clk);
    read_check(2'd0, 32'h0000_0155, "lb_rx0");
    read_check(2'd0, 32'h0000_01A3, "lb_rx1");
    read_check(2'd0, 32'h0000_0000, "lb_rx_empty");
    loop_en = 1'b0;
    repeat (2) @(negedge clk);

    // TX overflow: 6 writes with no gap, 5 frames leave the line
    fork
      begin
        for (int i = 0; i < 6; i++) bus_write(2'd1, 32'h11 + i);
        read_check(2'd2, 32'h0004_0022, "txovf_status");
        read_check(2'd1, 32'h0000_0100, "txovf_txdata_full");
      end
      begin
        for (int i = 0; i < 5; i++) begin
          grab_tx(gb, gf);
          check($sformatf("txovf_frame%0d_found", i), {31'b0, gf}, 32'h1);
          check($sformatf("txovf_frame%0d_byte", i), {24'b0, gb}, 32'h11 + i);
        end
      end
    join
    repeat (20) @(negedge clk);
    check("txovf_no_6th", {31'b0, uart_txd}, 32'h1);
    read_check(2'd2, 32'h0000_0024, "txovf_idle");
    bus_write(2'd2, 32'h20);
    read_check(2'd2, 32'h0000_0004, "txovf_cleared");

    // RX overflow: 5 frames, no reads
    for (int i = 0; i < 5; i++) send_frame(8'hA1 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    read_check(2'd2, 32'h0000_040D, "rxovf_status");
    for (int i = 0; i < 4; i++)
      read_check(2'd0, 32'h0000_03A1 + i, $sformatf("rxovf_byte%0d", i));
    read_check(2'd0, 32'h0000_0200, "rxovf_drained");
    bus_write(2'd2, 32'h08);
    read_check(2'd2, 32'h0000_0004, "rxovf_cleared");

    // Framing error then a good frame; also a short glitch
    send_frame(8'h33, 1'b0);
    drv_rxd = 1'b1;
    repeat (16) @(negedge clk);
    read_check(2'd2, 32'h0000_0014, "ferr_status");
    send_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    read_check(2'd0, 32'h0000_017E, "ferr_next_frame");
    bus_write(2'd2, 32'h10);
    read_check(2'd2, 32'h0000_0004, "ferr_cleared");
    drv_rxd = 1'b0;
    repeat (2) @(negedge clk);
    drv_rxd = 1'b1;
    repeat (20) @(negedge clk);
    read_check(2'd2, 32'h0000_0004, "glitch_ignored");

    // IRQ behaviour
    bus_write(2'd3, 32'h1);
    repeat (2) @(negedge clk);
    check("irq_rx_empty", {31'b0, ins_irq0_irq}, 32'h0);
    send_frame(8'h5A, 1'b1);
    check("irq_rx_raised", {31'b0, ins_irq0_irq}, 32'h1);
    read_check(2'd0, 32'h0000_015A, "irq_rx_byte");
    check("irq_rx_hold", {31'b0, ins_irq0_irq}, 32'h1);
    @(negedge clk);
    check("irq_rx_drop", {31'b0, ins_irq0_irq}, 32'h0);
    bus_write(2'd3, 32'h2);
    @(negedge clk);
    check("irq_txidle", {31'b0, ins_irq0_irq}, 32'h1);
    bus_write(2'd1, 32'h00);
    check("irq_tx_lag", {31'b0, ins_irq0_irq}, 32'h1);
    @(negedge clk);
    check("irq_tx_busy", {31'b0, ins_irq0_irq}, 32'h0);
    repeat (76) @(negedge clk);
    check("irq_tx_busy_late", {31'b0, ins_irq0_irq}, 32'h0);
    repeat (6) @(negedge clk);
    check("irq_tx_done", {31'b0, ins_irq0_irq}, 32'h1);

    // Reset in the middle of a TX data bit
    bus_write(2'd3, 32'h1);
    send_frame(8'h42, 1'b1);
    bus_write(2'd1, 32'h00);
    repeat (15) @(negedge clk);
    check("pre_rst_txd", {31'b0, uart_txd}, 32'h0);
    check("pre_rst_irq", {31'b0, ins_irq0_irq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_txd", {31'b0, uart_txd}, 32'h1);
    check("rst_async_irq", {31'b0, ins_irq0_irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read_check(2'd2, 32'h0000_0004, "post_rst_status");
    read_check(2'd0, 32'h0000_0000, "post_rst_rxdata");
    read_check(2'd3, 32'h0000_0000, "post_rst_control");
    repeat (20) @(negedge clk);
    check("post_rst_txd_idle", {31'b0, uart_txd}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
